// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : button_debouncer
// Brief    : Synchronizes and debounces one push-button; emits press/release/
//            long-press strobes and a wrapping count of accepted presses.
// Revision : 1.0 - initial release
// ============================================================================
module button_debouncer #(
    parameter bit ACTIVE_LOW        = 1'b1,
    parameter int DEBOUNCE_CYCLES   = 480000,
    parameter int LONG_PRESS_CYCLES = 48000000,
    parameter int CNT_W             = $clog2(LONG_PRESS_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_pin,
    output logic       pressed,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [7:0] press_count
);

    localparam logic [1:0] S_IDLE         = 2'd0;
    localparam logic [1:0] S_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] S_HELD         = 2'd2;
    localparam logic [1:0] S_RELEASE_WAIT = 2'd3;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_PRESS_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic             RELEASED_LVL = ACTIVE_LOW;

    generate
        if (DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES <= DEBOUNCE_CYCLES) begin : g_param_check
            $error("button_debouncer: need DEBOUNCE_CYCLES>=2 and LONG_PRESS_CYCLES>DEBOUNCE_CYCLES");
        end
    endgenerate

    logic             sync_meta;
    logic             sync_q;
    logic             raw_p;
    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             pressed_next;
    logic             press_next;
    logic             release_next;
    logic             long_next;
    logic [7:0]       count_next;

    assign raw_p = sync_q ^ ACTIVE_LOW;

    // State register; the sync flops and all outputs are registered here too.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta     <= RELEASED_LVL;
            sync_q        <= RELEASED_LVL;
            state         <= S_IDLE;
            cnt           <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            sync_meta     <= btn_pin;
            sync_q        <= sync_meta;
            state         <= state_next;
            cnt           <= cnt_next;
            pressed       <= pressed_next;
            press_pulse   <= press_next;
            release_pulse <= release_next;
            long_pulse    <= long_next;
            press_count   <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            S_IDLE: begin
                if (raw_p) begin
                    state_next = S_PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            S_PRESS_WAIT: begin
                if (!raw_p) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end else if (cnt == DEB_LAST) begin
                    state_next = S_HELD;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            S_HELD: begin
                if (!raw_p) begin
                    state_next = S_RELEASE_WAIT;
                    cnt_next   = '0;
                end else if (cnt != LONG_SAT) begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            S_RELEASE_WAIT: begin
                // A bounce back to pressed parks the counter at saturation so
                // the interrupted hold can never fire a long press.
                if (raw_p) begin
                    state_next = S_HELD;
                    cnt_next   = LONG_SAT;
                end else if (cnt == DEB_LAST) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        press_next   = (state == S_PRESS_WAIT) && raw_p && (cnt == DEB_LAST);
        release_next = (state == S_RELEASE_WAIT) && !raw_p && (cnt == DEB_LAST);
        long_next    = (state == S_HELD) && raw_p && (cnt == LONG_LAST);
        pressed_next = (state_next == S_HELD) || (state_next == S_RELEASE_WAIT);
        count_next   = press_next ? press_count + 8'd1 : press_count;
    end

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_button_debouncer
// Brief    : Scoreboard bench: stimulus queues expected strobes, a monitor
//            pops and compares them whenever the DUT emits a strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_debouncer;

    localparam bit ACTIVE_LOW = 1'b1;
    localparam int DEB        = 4;
    localparam int LONG       = 20;
    localparam int LAT        = 2 + DEB + 1;
    localparam int K_PRESS    = 0;
    localparam int K_RELEASE  = 1;
    localparam int K_LONG     = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_pin = 1'b1;
    logic       pressed;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic [7:0] press_count;

    button_debouncer #(
        .ACTIVE_LOW       (ACTIVE_LOW),
        .DEBOUNCE_CYCLES  (DEB),
        .LONG_PRESS_CYCLES(LONG)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_pin      (btn_pin),
        .pressed      (pressed),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .press_count  (press_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int at;
        int cnt;
    } evt_t;

    evt_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_count = 0;

    function automatic void chk(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    function automatic void push(int kind, int at, int cnt);
        evt_t e;
        e.kind = kind;
        e.at   = at;
        e.cnt  = cnt;
        sb.push_back(e);
    endfunction

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_press();
        btn_pin   = 1'b0;
        exp_count = (exp_count + 1) % 256;
        push(K_PRESS, cyc + LAT, exp_count);
    endtask

    task automatic do_release();
        btn_pin = 1'b1;
        push(K_RELEASE, cyc + LAT, exp_count);
    endtask

    // Monitor: every strobe must match the oldest queued expectation.
    int   mon_n;
    int   mon_kind;
    evt_t mon_e;
    always @(negedge clk) begin
        if (!rst) begin
            mon_n = int'(press_pulse) + int'(release_pulse) + int'(long_pulse);
            if (mon_n > 1) begin
                chk("strobe_exclusive", mon_n, 1);
            end else if (mon_n == 1) begin
                mon_kind = press_pulse ? K_PRESS : (release_pulse ? K_RELEASE : K_LONG);
                if (sb.size() == 0) begin
                    chk("unexpected_strobe_kind", mon_kind, -1);
                end else begin
                    mon_e = sb.pop_front();
                    chk("strobe_kind", mon_kind, mon_e.kind);
                    chk("strobe_cycle", cyc, mon_e.at);
                    chk("strobe_press_count", int'(press_count), mon_e.cnt);
                    chk("strobe_pressed", int'(pressed), (mon_e.kind == K_RELEASE) ? 0 : 1);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        rst     = 1'b1;
        btn_pin = 1'b1;
        wait_cycles(2);
        chk("reset_pressed", int'(pressed), 0);
        chk("reset_press_pulse", int'(press_pulse), 0);
        chk("reset_release_pulse", int'(release_pulse), 0);
        chk("reset_long_pulse", int'(long_pulse), 0);
        chk("reset_press_count", int'(press_count), 0);
        rst = 1'b0;
        wait_cycles(50);
        chk("idle_pressed", int'(pressed), 0);
        chk("idle_press_count", int'(press_count), 0);

        // Bounce shorter than the debounce window is rejected.
        repeat (5) begin
            btn_pin = 1'b0;
            wait_cycles(3);
            btn_pin = 1'b1;
            wait_cycles(2);
        end
        wait_cycles(10);
        chk("bounce_pressed", int'(pressed), 0);
        chk("bounce_press_count", int'(press_count), 0);

        // Clean short press.
        do_press();
        wait_cycles(10);
        chk("clean_pressed", int'(pressed), 1);
        chk("clean_press_count", int'(press_count), 1);
        do_release();
        wait_cycles(10);
        chk("clean_released", int'(pressed), 0);

        // Long press: long strobe 20 cycles after the press strobe.
        c0 = cyc;
        do_press();
        push(K_LONG, c0 + LAT + LONG, exp_count);
        wait_cycles(40);
        do_release();
        wait_cycles(10);
        chk("long_released", int'(pressed), 0);

        // Release bounce: returns to held, no release, long press disarmed.
        do_press();
        wait_cycles(10);
        btn_pin = 1'b1;
        wait_cycles(2);
        btn_pin = 1'b0;
        wait_cycles(30);
        chk("relbounce_pressed", int'(pressed), 1);
        chk("relbounce_press_count", int'(press_count), 3);
        do_release();
        wait_cycles(10);

        // 256 presses wrap the counter through 255 -> 0 back to 3.
        for (int i = 0; i < 256; i++) begin
            do_press();
            wait_cycles(9);
            if (exp_count == 0) chk("wrap_to_zero", int'(press_count), 0);
            do_release();
            wait_cycles(9);
        end
        chk("wrap_final_count", int'(press_count), 3);

        // Reset while held aborts silently; held button re-debounces as a new press.
        do_press();
        wait_cycles(12);
        chk("midheld_pressed", int'(pressed), 1);
        rst = 1'b1;
        wait_cycles(2);
        chk("midheld_rst_pressed", int'(pressed), 0);
        chk("midheld_rst_release_pulse", int'(release_pulse), 0);
        chk("midheld_rst_press_count", int'(press_count), 0);
        c0        = cyc;
        rst       = 1'b0;
        exp_count = 1;
        push(K_PRESS, c0 + LAT, exp_count);
        wait_cycles(12);
        chk("post_rst_pressed", int'(pressed), 1);
        do_release();
        wait_cycles(10);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
